// File: rtl/sort_vec_checker.sv
// Post-run self-check engine: walks a DCCM vector through a single-outstanding
// read port and reports ordering violations plus the first index matching a key.
module sort_vec_checker #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  len,
  input  logic              mode_desc,
  input  logic              mode_signed,
  input  logic [DATA_W-1:0] key,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              sorted,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [CNT_W-1:0]  first_viol_idx,
  output logic              key_found,
  output logic [CNT_W-1:0]  key_idx
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [CNT_W-1:0]  len_reg, len_next;
  logic              desc_reg, desc_next;
  logic              signed_reg, signed_next;
  logic [DATA_W-1:0] key_reg, key_next;
  logic [CNT_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] prev_reg, prev_next;
  logic [CNT_W-1:0]  viol_cnt_reg, viol_cnt_next;
  logic [CNT_W-1:0]  first_viol_idx_reg, first_viol_idx_next;
  logic              key_found_reg, key_found_next;
  logic [CNT_W-1:0]  key_idx_reg, key_idx_next;
  logic              sorted_reg, sorted_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
  logic              mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;

  logic cur_lt_prev, cur_gt_prev, viol_hit, last_elem;

  always_comb begin
    if (signed_reg) begin
      cur_lt_prev = $signed(mem_rdata) < $signed(prev_reg);
      cur_gt_prev = $signed(mem_rdata) > $signed(prev_reg);
    end else begin
      cur_lt_prev = mem_rdata < prev_reg;
      cur_gt_prev = mem_rdata > prev_reg;
    end
  end

  // Element 0 has no predecessor, so it can never be the later half of a violation.
  assign viol_hit  = (idx_reg != '0) && (desc_reg ? cur_gt_prev : cur_lt_prev);
  assign last_elem = (idx_reg == (len_reg - CNT_W'(1)));

  always_comb begin
    state_next          = state_reg;
    base_next           = base_reg;
    len_next            = len_reg;
    desc_next           = desc_reg;
    signed_next         = signed_reg;
    key_next            = key_reg;
    idx_next            = idx_reg;
    prev_next           = prev_reg;
    viol_cnt_next       = viol_cnt_reg;
    first_viol_idx_next = first_viol_idx_reg;
    key_found_next      = key_found_reg;
    key_idx_next        = key_idx_reg;
    sorted_next         = sorted_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next           = base_addr;
          len_next            = len;
          desc_next           = mode_desc;
          signed_next         = mode_signed;
          key_next            = key;
          idx_next            = '0;
          viol_cnt_next       = '0;
          first_viol_idx_next = '0;
          key_found_next      = 1'b0;
          key_idx_next        = '0;
          sorted_next         = (len == '0);
          state_next          = (len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        // A grant coinciding with abort still owes us an rvalid, which must be drained.
        if (abort)        state_next = mem_gnt ? DRAIN : IDLE;
        else if (mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_next = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          prev_next = mem_rdata;
          if (viol_hit) begin
            if (viol_cnt_reg == '0) first_viol_idx_next = idx_reg;
            if (viol_cnt_reg != '1) viol_cnt_next = viol_cnt_reg + CNT_W'(1);
          end
          if ((mem_rdata == key_reg) && !key_found_reg) begin
            key_found_next = 1'b1;
            key_idx_next   = idx_reg;
          end
          if (last_elem) begin
            sorted_next = (viol_cnt_next == '0);
            state_next  = DONE;
          end else begin
            idx_next   = idx_reg + CNT_W'(1);
            state_next = REQ;
          end
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_next = IDLE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    mem_req_next  = (state_next == REQ);
    mem_addr_next = (state_next == REQ) ? (base_next + ADDR_W'(idx_next)) : mem_addr_reg;
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      base_reg           <= '0;
      len_reg            <= '0;
      desc_reg           <= 1'b0;
      signed_reg         <= 1'b0;
      key_reg            <= '0;
      idx_reg            <= '0;
      prev_reg           <= '0;
      viol_cnt_reg       <= '0;
      first_viol_idx_reg <= '0;
      key_found_reg      <= 1'b0;
      key_idx_reg        <= '0;
      sorted_reg         <= 1'b0;
      done_reg           <= 1'b0;
      busy_reg           <= 1'b0;
      mem_req_reg        <= 1'b0;
      mem_addr_reg       <= '0;
    end else begin
      state_reg          <= state_next;
      base_reg           <= base_next;
      len_reg            <= len_next;
      desc_reg           <= desc_next;
      signed_reg         <= signed_next;
      key_reg            <= key_next;
      idx_reg            <= idx_next;
      prev_reg           <= prev_next;
      viol_cnt_reg       <= viol_cnt_next;
      first_viol_idx_reg <= first_viol_idx_next;
      key_found_reg      <= key_found_next;
      key_idx_reg        <= key_idx_next;
      sorted_reg         <= sorted_next;
      done_reg           <= done_next;
      busy_reg           <= busy_next;
      mem_req_reg        <= mem_req_next;
      mem_addr_reg       <= mem_addr_next;
    end
  end

  assign mem_req        = mem_req_reg;
  assign mem_addr       = mem_addr_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign sorted         = sorted_reg;
  assign viol_cnt       = viol_cnt_reg;
  assign first_viol_idx = first_viol_idx_reg;
  assign key_found      = key_found_reg;
  assign key_idx        = key_idx_reg;

endmodule

// File: tb/tb_sort_vec_checker.sv
// Directed bench for sort_vec_checker with a small DCCM responder that can
// insert grant/rvalid stalls.
module tb_sort_vec_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        mode_desc = 1'b0;
  logic        mode_signed = 1'b0;
  logic [31:0] key = '0;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, sorted, key_found;
  logic [15:0] viol_cnt, first_viol_idx, key_idx;

  int errors = 0;
  int checks = 0;

  sort_vec_checker #(.DATA_W(32), .ADDR_W(14), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .len(len), .mode_desc(mode_desc),
    .mode_signed(mode_signed), .key(key),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .sorted(sorted), .viol_cnt(viol_cnt),
    .first_viol_idx(first_viol_idx), .key_found(key_found), .key_idx(key_idx)
  );

  always #5 clk = ~clk;

  // Memory responder: acts on the falling edge so the DUT sees stable inputs.
  logic [31:0] mem [0:16383];
  logic [13:0] addr_q [$];
  bit          pend = 1'b0;
  logic [13:0] pend_addr = '0;
  int          gnt_wait = 0, rv_wait = 0;
  int          req_cnt = 0, gnt_cnt = 0, rv_cnt = 0, done_cnt = 0;
  bit          stall_en = 1'b0;
  int          rv_fixed = 0;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (done) done_cnt++;
    if (mem_req) req_cnt++;
    if (rst) begin
      pend     = 1'b0;
      gnt_wait = 0;
    end else if (pend) begin
      if (rv_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[pend_addr];
        pend       = 1'b0;
        rv_cnt++;
      end else begin
        rv_wait--;
      end
    end else if (mem_req) begin
      if (gnt_wait == 0) begin
        mem_gnt   = 1'b1;
        pend      = 1'b1;
        pend_addr = mem_addr;
        addr_q.push_back(mem_addr);
        gnt_cnt++;
        rv_wait   = stall_en ? int'($urandom_range(0, 3)) : rv_fixed;
        gnt_wait  = stall_en ? int'($urandom_range(0, 3)) : 0;
      end else begin
        gnt_wait--;
      end
    end
  end

  task automatic run_walk(input logic [13:0] b, input logic [15:0] n, input logic d,
                          input logic s, input logic [31:0] k, input bit poke,
                          output int cyc);
    repeat (2) @(negedge clk);
    base_addr = b; len = n; mode_desc = d; mode_signed = s; key = k; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 10) begin start = 1'b1; len = 16'd3; key = 32'd0; end
      if (poke && cyc == 11) begin start = 1'b0; len = n; key = k; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL walk_timeout base=%h len=%0d: done=%b after %0d cycles, required 1", b, n, done, cyc);
    end
    $display("walk base=%h len=%0d desc=%0d signed=%0d key=%0d -> cycles=%0d sorted=%0d viol=%0d first=%0d found=%0d kidx=%0d",
             b, n, d, s, k, cyc, sorted, viol_cnt, first_viol_idx, key_found, key_idx);
  endtask

  task automatic load_asc(input bit swap56);
    for (int i = 0; i < 24; i++) mem[14'h800 + i] = 32'(10 * (i + 1));
    if (swap56) begin
      mem[14'h805] = 32'd70;
      mem[14'h806] = 32'd60;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (sorted !== 1'b0) begin errors++; $display("FAIL rst_sorted got=%b exp=0", sorted); end
    checks++; if (viol_cnt !== 16'd0) begin errors++; $display("FAIL rst_viol_cnt got=%0d exp=0", viol_cnt); end
    checks++; if (first_viol_idx !== 16'd0) begin errors++; $display("FAIL rst_first_viol got=%0d exp=0", first_viol_idx); end
    checks++; if (key_found !== 1'b0) begin errors++; $display("FAIL rst_key_found got=%b exp=0", key_found); end
    checks++; if (key_idx !== 16'd0) begin errors++; $display("FAIL rst_key_idx got=%0d exp=0", key_idx); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ascending();
    int cyc;
    load_asc(1'b0);
    run_walk(14'h800, 16'd24, 1'b0, 1'b0, 32'd120, 1'b0, cyc);
    checks++; if (cyc != 49) begin errors++; $display("FAIL asc_latency got=%0d exp=49", cyc); end
    checks++; if (sorted !== 1'b1) begin errors++; $display("FAIL asc_sorted got=%b exp=1", sorted); end
    checks++; if (viol_cnt !== 16'd0) begin errors++; $display("FAIL asc_viol got=%0d exp=0", viol_cnt); end
    checks++; if (key_found !== 1'b1) begin errors++; $display("FAIL asc_key_found got=%b exp=1", key_found); end
    checks++; if (key_idx !== 16'd11) begin errors++; $display("FAIL asc_key_idx got=%0d exp=11", key_idx); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL asc_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_violations();
    int cyc;
    load_asc(1'b1);
    run_walk(14'h800, 16'd24, 1'b0, 1'b0, 32'd120, 1'b0, cyc);
    checks++; if (sorted !== 1'b0) begin errors++; $display("FAIL swap_sorted got=%b exp=0", sorted); end
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL swap_viol got=%0d exp=1", viol_cnt); end
    checks++; if (first_viol_idx !== 16'd6) begin errors++; $display("FAIL swap_first got=%0d exp=6", first_viol_idx); end
    load_asc(1'b0);
    run_walk(14'h800, 16'd24, 1'b1, 1'b0, 32'd999, 1'b0, cyc);
    checks++; if (viol_cnt !== 16'd23) begin errors++; $display("FAIL desc_viol got=%0d exp=23", viol_cnt); end
    checks++; if (first_viol_idx !== 16'd1) begin errors++; $display("FAIL desc_first got=%0d exp=1", first_viol_idx); end
    checks++; if (key_found !== 1'b0) begin errors++; $display("FAIL desc_key_found got=%b exp=0", key_found); end
  endtask

  task automatic test_signed();
    int cyc;
    mem[14'h100] = -32'sd5;
    mem[14'h101] = -32'sd1;
    mem[14'h102] = 32'd0;
    mem[14'h103] = 32'd7;
    run_walk(14'h100, 16'd4, 1'b0, 1'b1, 32'd0, 1'b0, cyc);
    checks++; if (sorted !== 1'b1) begin errors++; $display("FAIL signed_sorted got=%b exp=1", sorted); end
    checks++; if (key_idx !== 16'd2) begin errors++; $display("FAIL signed_key_idx got=%0d exp=2", key_idx); end
    run_walk(14'h100, 16'd4, 1'b0, 1'b0, 32'd0, 1'b0, cyc);
    checks++; if (viol_cnt !== 16'd1) begin errors++; $display("FAIL unsigned_viol got=%0d exp=1", viol_cnt); end
    checks++; if (first_viol_idx !== 16'd2) begin errors++; $display("FAIL unsigned_first got=%0d exp=2", first_viol_idx); end
  endtask

  task automatic test_len0_and_wrap();
    int cyc;
    int r0;
    int q0;
    logic [13:0] exp_a [4];
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    r0 = req_cnt;
    run_walk(14'h0200, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL len0_latency got=%0d exp=1", cyc); end
    checks++; if (sorted !== 1'b1) begin errors++; $display("FAIL len0_sorted got=%b exp=1", sorted); end
    checks++; if (req_cnt != r0) begin errors++; $display("FAIL len0_no_req got=%0d req cycles exp=0", req_cnt - r0); end
    mem[14'h3FFE] = 32'd1; mem[14'h3FFF] = 32'd2; mem[14'h0000] = 32'd3; mem[14'h0001] = 32'd4;
    q0 = addr_q.size();
    run_walk(14'h3FFE, 16'd4, 1'b0, 1'b0, 32'd4, 1'b0, cyc);
    checks++; if (addr_q.size() - q0 != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", addr_q.size() - q0); end
    for (int i = 0; i < 4 && q0 + i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[q0 + i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, addr_q[q0 + i], exp_a[i]); end
    end
    checks++; if (sorted !== 1'b1 || key_idx !== 16'd3) begin errors++; $display("FAIL wrap_result got sorted=%b kidx=%0d exp sorted=1 kidx=3", sorted, key_idx); end
  endtask

  task automatic test_stalls();
    int cyc;
    int exp_viol;
    for (int i = 0; i < 64; i++) mem[14'h1000 + i] = 32'((i * 37) % 50);
    exp_viol = 0;
    for (int i = 1; i < 64; i++) if (((i * 37) % 50) < (((i - 1) * 37) % 50)) exp_viol++;
    for (int pass = 0; pass < 2; pass++) begin
      stall_en = (pass == 1);
      run_walk(14'h1000, 16'd64, 1'b0, 1'b0, 32'd23, (pass == 1), cyc);
      if (pass == 0) begin
        checks++; if (cyc != 129) begin errors++; $display("FAIL stall0_latency got=%0d exp=129", cyc); end
      end
      checks++; if (viol_cnt !== 16'(exp_viol)) begin errors++; $display("FAIL stall%0d_viol got=%0d exp=%0d", pass, viol_cnt, exp_viol); end
      checks++; if (first_viol_idx !== 16'd2) begin errors++; $display("FAIL stall%0d_first got=%0d exp=2", pass, first_viol_idx); end
      checks++; if (key_found !== 1'b1 || key_idx !== 16'd29) begin errors++; $display("FAIL stall%0d_key got found=%b idx=%0d exp found=1 idx=29", pass, key_found, key_idx); end
      checks++; if (sorted !== 1'b0) begin errors++; $display("FAIL stall%0d_sorted got=%b exp=0", pass, sorted); end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_abort();
    int g0, r0, d0, n;
    load_asc(1'b0);
    rv_fixed = 3;
    repeat (2) @(negedge clk);
    g0 = gnt_cnt; r0 = rv_cnt; d0 = done_cnt;
    base_addr = 14'h800; len = 16'd24; mode_desc = 1'b0; mode_signed = 1'b0; key = 32'd120; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (gnt_cnt - g0 < 4 && n < 200) begin @(posedge clk); #1; n++; end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL abort_drain got busy=%b req=%b exp busy=1 req=0", busy, mem_req); end
    checks++; if (rv_cnt - r0 != 3) begin errors++; $display("FAIL abort_pending got=%0d rvalids exp=3", rv_cnt - r0); end
    n = 0;
    while (busy && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp=0", busy); end
    checks++; if (rv_cnt - r0 != 4) begin errors++; $display("FAIL abort_drained got=%0d rvalids exp=4", rv_cnt - r0); end
    checks++; if (done_cnt != d0 || sorted !== 1'b0) begin errors++; $display("FAIL abort_no_done got pulses=%0d sorted=%b exp 0 and 0", done_cnt - d0, sorted); end
    $display("walk aborted at element 3 after %0d drain cycles", n);
    rv_fixed = 0;
  endtask

  task automatic test_reset_mid();
    int cyc, d0;
    load_asc(1'b0);
    repeat (2) @(negedge clk);
    base_addr = 14'h800; len = 16'd24; mode_desc = 1'b0; mode_signed = 1'b0; key = 32'd120; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mem_req, mem_addr, sorted, viol_cnt, first_viol_idx, key_found, key_idx} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got busy=%b done=%b req=%b addr=%h sorted=%b viol=%0d first=%0d found=%b kidx=%0d exp all 0",
               busy, done, mem_req, mem_addr, sorted, viol_cnt, first_viol_idx, key_found, key_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrst_no_done got pulses=%0d exp=0", done_cnt - d0); end
    run_walk(14'h800, 16'd24, 1'b0, 1'b0, 32'd120, 1'b0, cyc);
    checks++; if (cyc != 49 || sorted !== 1'b1 || key_idx !== 16'd11) begin errors++; $display("FAIL midrst_rerun got cyc=%0d sorted=%b kidx=%0d exp 49 1 11", cyc, sorted, key_idx); end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_violations();
    test_signed();
    test_len0_and_wrap();
    test_stalls();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sort_vec_checker.md
# sort_vec_checker

Hardware self-check engine for the lp_riscv data-memory vector sort test. After the core raises its done indication, the engine walks a vector of `len` words in DCCM through a single-outstanding read port. It reports whether the vector is ordered, how many adjacent pairs violate the order, where the first violation is, and the index of a search key (the stored ID). The vector base, length, order direction and signedness are run-time inputs, and data/address/count widths are parameters. This replaces the fixed 24-entry, hierarchy-peek, ascending-only check.

## Interface
- DATA_W, 32, memory word width and compared value width
- ADDR_W, 14, word-address width (16384-word DCCM)
- CNT_W, 16, width of length, index and count fields

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  1-cycle request; sampled only in IDLE
- abort  in  1  terminate current walk
- base_addr  in  ADDR_W  word address of element 0
- len  in  CNT_W  element count
- mode_desc  in  1  0 = non-decreasing check, 1 = non-increasing check
- mode_signed  in  1  1 = two's-complement compare, 0 = unsigned
- key  in  DATA_W  search value
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read word address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; exactly one per grant, ≥1 cycle after grant
- mem_rdata  in  DATA_W  read data
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse, results valid
- sorted  out  1  1 = no violations
- viol_cnt  out  CNT_W  number of violating adjacent pairs
- first_viol_idx  out  CNT_W  index of the later element of the first violating pair
- key_found  out  1  key matched at least one element
- key_idx  out  CNT_W  lowest matching index

## Operation
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE:
  - On `start`, latch base_addr, len, mode_desc, mode_signed and key.
  - Clear idx, viol_cnt, first_viol_idx, key_found, key_idx and sorted.
  - If len==0, go to DONE with sorted=1. Otherwise go to REQ.
- REQ:
  - mem_req=1 and mem_addr=(base+idx) mod 2^ADDR_W; the address wraps silently.
  - On mem_gnt, go to WAIT. mem_req stays high until granted.
- WAIT:
  - On mem_rvalid, register the word as prev.
  - If idx>0, compare the word (cur) with prev. A violation is cur<prev when mode_desc=0, or cur>prev when mode_desc=1; signedness follows mode_signed. Equal values never violate.
  - On each violation, viol_cnt saturates at all-ones. first_viol_idx is written only on the first violation.
  - If cur==key and !key_found, set key_found=1 and key_idx=idx.
  - If idx==len-1, go to DONE. Otherwise idx++ and go to REQ.
- DONE:
  - done=1 for one cycle; sorted=(viol_cnt==0).
  - Return to IDLE.
  - Result outputs hold until the next accepted start.
- `start` while busy is ignored.
- `abort`:
  - In REQ: go to IDLE immediately. A grant in the same cycle is accepted and its rvalid is then drained, so that case goes to DRAIN instead.
  - In WAIT: go to DRAIN. DRAIN ignores rvalid data and goes to IDLE on rvalid.
  - An aborted run never pulses done and leaves sorted=0.
- mem_rvalid outside WAIT/DRAIN is ignored.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, sorted=0, viol_cnt=0, first_viol_idx=0, key_found=0, key_idx=0; state IDLE.
- Reset during a walk returns to IDLE next edge and drops mem_req. No done pulse is produced.
- With zero-wait grant and rvalid one cycle after grant, each element costs 2 cycles:
  - If start is sampled at edge 0, done is high in cycle 2·len+1.
  - For len==0, done is high in cycle 1.
- Each extra grant or rvalid wait cycle adds one cycle per element.
- mem_req and mem_addr are registered; mem_addr is stable while mem_req is high and not granted.
- All outputs are registered. Results update on the edge that completes the last rvalid, and done follows in the next cycle.

## Test plan
- Ascending unsigned, len=24, base=0x800, values 10,20,…,240, key=120 → done at cycle 49; sorted=1, viol_cnt=0, key_found=1, key_idx=11.
- Same data with elements 5 and 6 swapped (60↔70), mode_desc=0 → sorted=0, viol_cnt=1, first_viol_idx=6. With mode_desc=1 on the sorted data → viol_cnt=23, first_viol_idx=1.
- Signed check with data −5, −1, 0, 7 → mode_signed=1 gives sorted=1; mode_signed=0 gives viol_cnt=1, first_viol_idx=2.
- len=0 → done in cycle 1 with sorted=1 and no mem_req. base=0x3FFE, len=4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Random 0–3-cycle gnt/rvalid stalls over len=64 → results identical to the zero-stall run. start pulsed while busy → no effect.
- abort asserted in WAIT at element 3 → DRAIN until rvalid, then IDLE with no done pulse. rst asserted mid-walk → all outputs at reset values next cycle. A new start afterwards completes normally.
